ysyx_24110015_lsu: RTL

- Multi-cycle load/store unit directly downstream of the execute stage. Replaces direct DPI memory calls with a handshake-driven memory port.
- Accepts one op per transaction from EXU (address = ALU result, store data, MemRead/MemWrite/MemOp). Drives a word-aligned memory request. Returns a sign/zero-extended load value (or the passed-through ALU result) to write-back over a valid/ready handshake.

---
 rtl/ysyx_24110015_lsu_pkg.sv | 39 +++
 rtl/ysyx_24110015_lsu_if.sv | 41 ++++
 rtl/ysyx_24110015_lsu_align.sv | 41 ++++
 rtl/ysyx_24110015_lsu.sv | 136 +++++++++++++
 4 files changed

// File: rtl/ysyx_24110015_lsu_pkg.sv
// Shared definitions for the load/store unit: memory-op encodings, FSM states,
// byte-lane mask constants and access-legality helpers.
package ysyx_24110015_lsu_pkg;

    typedef enum logic [2:0] {
        MEMOP_B  = 3'b000,
        MEMOP_H  = 3'b001,
        MEMOP_W  = 3'b010,
        MEMOP_BU = 3'b100,
        MEMOP_HU = 3'b101
    } memop_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    localparam logic [3:0] MASK_B = 4'b0001;
    localparam logic [3:0] MASK_H = 4'b0011;
    localparam logic [3:0] MASK_W = 4'b1111;

    function automatic logic memop_legal(input logic [2:0] op);
        case (op)
            MEMOP_B, MEMOP_H, MEMOP_W, MEMOP_BU, MEMOP_HU: return 1'b1;
            default:                                       return 1'b0;
        endcase
    endfunction

    function automatic logic memop_misaligned(input logic [2:0] op, input logic [1:0] off);
        case (op)
            MEMOP_H, MEMOP_HU: return off[0];
            MEMOP_W:           return off != 2'b00;
            default:           return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ysyx_24110015_lsu_if.sv
// Bundles the EXU-side request, memory port and WBU-side result of the LSU.
// slave = the LSU itself, master = whoever drives it (pipeline + memory).
interface ysyx_24110015_lsu_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] in_addr;
    logic [XLEN-1:0] in_wdata;
    logic            in_memread;
    logic            in_memwrite;
    logic [2:0]      in_memop;

    logic            mem_req_valid;
    logic            mem_req_ready;
    logic [XLEN-1:0] mem_addr;
    logic            mem_wen;
    logic [XLEN-1:0] mem_wdata;
    logic [3:0]      mem_wmask;
    logic            mem_rsp_valid;
    logic [XLEN-1:0] mem_rdata;

    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_data;
    logic            out_err;

    modport slave (
        input  in_valid, in_addr, in_wdata, in_memread, in_memwrite, in_memop,
        input  mem_req_ready, mem_rsp_valid, mem_rdata, out_ready,
        output in_ready, mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
        output out_valid, out_data, out_err
    );

    modport master (
        output in_valid, in_addr, in_wdata, in_memread, in_memwrite, in_memop,
        output mem_req_ready, mem_rsp_valid, mem_rdata, out_ready,
        input  in_ready, mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
        input  out_valid, out_data, out_err
    );
endinterface

// File: rtl/ysyx_24110015_lsu_align.sv
// Combinational byte-lane logic: store data shift + byte mask, and load word
// shift + sign/zero extension. Shared with the later cache datapath.
module ysyx_24110015_lsu_align
    import ysyx_24110015_lsu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      i_memop,
    input  logic [1:0]      i_off,
    input  logic [XLEN-1:0] i_wdata,
    input  logic [XLEN-1:0] i_rdata,
    output logic [XLEN-1:0] o_wdata,
    output logic [3:0]      o_wmask,
    output logic [XLEN-1:0] o_rdata
);
    logic [4:0]      w_shamt;
    logic [XLEN-1:0] w_rshift;

    assign w_shamt  = {i_off, 3'b000};
    assign o_wdata  = i_wdata << w_shamt;
    assign w_rshift = i_rdata >> w_shamt;

    // Store size comes from the low two bits, so bu/hu encodings store as b/h.
    always_comb begin
        case (i_memop[1:0])
            2'b00:   o_wmask = MASK_B << i_off;
            2'b01:   o_wmask = MASK_H << i_off;
            default: o_wmask = MASK_W;
        endcase
    end

    always_comb begin
        case (i_memop)
            MEMOP_B:  o_rdata = {{(XLEN-8){w_rshift[7]}}, w_rshift[7:0]};
            MEMOP_H:  o_rdata = {{(XLEN-16){w_rshift[15]}}, w_rshift[15:0]};
            MEMOP_BU: o_rdata = {{(XLEN-8){1'b0}}, w_rshift[7:0]};
            MEMOP_HU: o_rdata = {{(XLEN-16){1'b0}}, w_rshift[15:0]};
            default:  o_rdata = w_rshift;
        endcase
    end
endmodule

// File: rtl/ysyx_24110015_lsu.sv
// Multi-cycle load/store unit: accepts one EXU op, issues a word-aligned memory
// request with a response timeout, and hands the extended result to write-back.
module ysyx_24110015_lsu
    import ysyx_24110015_lsu_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 255
) (
    input logic                  clk,
    input logic                  rst,
    ysyx_24110015_lsu_if.slave   bus
);
    localparam logic [15:0] TIMEOUT_W = 16'(TIMEOUT);

    state_e          r_state;
    state_e          w_next;
    logic [XLEN-1:0] r_addr;
    logic [XLEN-1:0] r_wdata;
    logic [XLEN-1:0] r_data;
    logic [2:0]      r_memop;
    logic            r_read;
    logic            r_write;
    logic            r_err;
    logic [15:0]     r_cnt;

    logic            w_is_mem;
    logic            w_bad;
    logic [15:0]     w_cnt_inc;
    logic            w_timeout;
    logic [XLEN-1:0] w_st_wdata;
    logic [3:0]      w_st_wmask;
    logic [XLEN-1:0] w_ld_data;

    assign w_is_mem  = bus.in_memread | bus.in_memwrite;
    assign w_bad     = (bus.in_memread & bus.in_memwrite)
                     | (w_is_mem & (~memop_legal(bus.in_memop)
                                  | memop_misaligned(bus.in_memop, bus.in_addr[1:0])));
    assign w_cnt_inc = r_cnt + 16'd1;
    assign w_timeout = (w_cnt_inc == TIMEOUT_W);

    ysyx_24110015_lsu_align #(.XLEN(XLEN)) u_align (
        .i_memop (r_memop),
        .i_off   (r_addr[1:0]),
        .i_wdata (r_wdata),
        .i_rdata (bus.mem_rdata),
        .o_wdata (w_st_wdata),
        .o_wmask (w_st_wmask),
        .o_rdata (w_ld_data)
    );

    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) r_state <= ST_IDLE;
        else      r_state <= w_next;
    end

    // NOTE: default assignment first so no path through the case infers a latch.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (bus.in_valid) w_next = (w_is_mem && !w_bad) ? ST_REQ : ST_DONE;
            ST_REQ:  if (bus.mem_req_ready) w_next = ST_WAIT;
            ST_WAIT: if (bus.mem_rsp_valid || w_timeout) w_next = ST_DONE;
            ST_DONE: if (bus.out_ready) w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready      = 1'b0;
        bus.mem_req_valid = 1'b0;
        bus.mem_addr      = '0;
        bus.mem_wen       = 1'b0;
        bus.mem_wdata     = '0;
        bus.mem_wmask     = 4'b0000;
        bus.out_valid     = 1'b0;
        bus.out_data      = '0;
        bus.out_err       = 1'b0;
        case (r_state)
            ST_IDLE: bus.in_ready = 1'b1;
            ST_REQ: begin
                bus.mem_req_valid = 1'b1;
                bus.mem_addr      = {r_addr[XLEN-1:2], 2'b00};
                bus.mem_wen       = r_write;
                if (r_write) begin
                    bus.mem_wdata = w_st_wdata;
                    bus.mem_wmask = w_st_wmask;
                end
            end
            ST_DONE: begin
                bus.out_valid = 1'b1;
                bus.out_data  = r_data;
                bus.out_err   = r_err;
            end
            default: ;
        endcase
    end

    // NOTE: datapath flops are reset too, so nothing stale reaches the outputs
    // after a mid-transaction reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_addr  <= '0;
            r_wdata <= '0;
            r_data  <= '0;
            r_memop <= 3'b000;
            r_read  <= 1'b0;
            r_write <= 1'b0;
            r_err   <= 1'b0;
            r_cnt   <= 16'd0;
        end else begin
            case (r_state)
                ST_IDLE: if (bus.in_valid) begin
                    r_addr  <= bus.in_addr;
                    r_wdata <= bus.in_wdata;
                    r_memop <= bus.in_memop;
                    r_read  <= bus.in_memread;
                    r_write <= bus.in_memwrite;
                    r_err   <= w_bad;
                    r_data  <= w_is_mem ? '0 : bus.in_addr;
                end
                ST_REQ: if (bus.mem_req_ready) r_cnt <= 16'd0;
                ST_WAIT: begin
                    // A response on the final counted cycle still beats the timeout.
                    if (bus.mem_rsp_valid) begin
                        if (r_read) r_data <= w_ld_data;
                    end else begin
                        r_cnt <= w_cnt_inc;
                        if (w_timeout) r_err <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
